// File: rtl/div_arb_pkg.sv
// Shared types and constants for the divider arbiter.
package div_arb_pkg;

  localparam int unsigned DEFAULT_DATA_W = 4;

  // Error codes reported on err_out
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_DIV0    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [3:0] {
    StIdle,
    StSendA,
    StGapA,
    StSendB,
    StGapB,
    StWait,
    StSample,
    StResp,
    StAbort
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request after ptr, with wrap.
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned PtrW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [PtrW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic            valid
);

  // Scan ptr+1 .. ptr+N (mod N); the first hit wins.
  always_comb begin
    int unsigned     sum;
    logic [PtrW-1:0] idx;
    grant = '0;
    valid = 1'b0;
    sum   = 0;
    idx   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      sum = 32'(ptr) + k;
      if (sum >= N) sum = sum - N;
      idx = PtrW'(sum);
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one two-pulse signed divider among N requesters, round-robin,
// with a watchdog that resets the divider if it never answers.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned DATA_W  = DEFAULT_DATA_W,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N-1:0]        req,
  input  logic [N*DATA_W-1:0] a_in,
  input  logic [N*DATA_W-1:0] b_in,
  output logic [N-1:0]        ack,
  output logic [N-1:0]        done,
  output logic [DATA_W-1:0]   res_out,
  output logic [1:0]          err_out,
  output logic                div_reset,
  output logic                div_valid_in,
  output logic [DATA_W-1:0]   div_d_in,
  input  logic                div_valid_out,
  input  logic [DATA_W-1:0]   div_d_out,
  input  logic                div_error_out
);

  localparam int unsigned PtrW = $clog2(N);
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  state_e            state_q;
  logic [PtrW-1:0]   ptr_q;
  logic [N-1:0]      gnt_q;
  logic [DATA_W-1:0] b_q;
  logic [CntW-1:0]   wdog_q;

  logic [N-1:0]      pick_gnt;
  logic              pick_vld;
  logic [PtrW-1:0]   pick_idx;
  logic [DATA_W-1:0] pick_a;
  logic [DATA_W-1:0] pick_b;

  rr_arbiter #(
    .N    (N),
    .PtrW (PtrW)
  ) u_rr (
    .req   (req),
    .ptr   (ptr_q),
    .grant (pick_gnt),
    .valid (pick_vld)
  );

  // Decode the one-hot pick into an index and the chosen operand pair.
  always_comb begin
    pick_idx = '0;
    pick_a   = '0;
    pick_b   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pick_gnt[i]) begin
        pick_idx = PtrW'(i);
        pick_a   = a_in[i*DATA_W +: DATA_W];
        pick_b   = b_in[i*DATA_W +: DATA_W];
      end
    end
  end

  // Sequencer FSM; every output is set on the transition into its state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      ptr_q        <= PtrW'(N - 1);
      gnt_q        <= '0;
      b_q          <= '0;
      wdog_q       <= '0;
      ack          <= '0;
      done         <= '0;
      res_out      <= '0;
      err_out      <= ERR_NONE;
      div_reset    <= 1'b1;
      div_valid_in <= 1'b0;
      div_d_in     <= '0;
    end else begin
      ack          <= '0;
      done         <= '0;
      div_valid_in <= 1'b0;
      div_reset    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pick_vld) begin
            gnt_q        <= pick_gnt;
            ptr_q        <= pick_idx;
            b_q          <= pick_b;
            ack          <= pick_gnt;
            div_valid_in <= 1'b1;
            div_d_in     <= pick_a;
            state_q      <= StSendA;
          end
        end
        StSendA: state_q <= StGapA;
        StGapA: begin
          div_valid_in <= 1'b1;
          div_d_in     <= b_q;
          state_q      <= StSendB;
        end
        StSendB: state_q <= StGapB;
        StGapB: begin
          wdog_q  <= '0;
          state_q <= StWait;
        end
        StWait: begin
          // A divider answer wins over a watchdog expiry in the same cycle
          if (div_valid_out) begin
            state_q <= StSample;
          end else if (wdog_q == CntW'(TIMEOUT - 1)) begin
            wdog_q    <= '0;
            div_reset <= 1'b1;
            state_q   <= StAbort;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        StSample: begin
          done <= gnt_q;
          if (div_error_out) begin
            res_out <= '0;
            err_out <= ERR_DIV0;
          end else begin
            res_out <= div_d_out;
            err_out <= ERR_NONE;
          end
          state_q <= StResp;
        end
        StResp: state_q <= StIdle;
        StAbort: begin
          // Hold the divider in reset for two cycles, then report the timeout
          if (wdog_q == CntW'(1)) begin
            done    <= gnt_q;
            res_out <= '0;
            err_out <= ERR_TIMEOUT;
            state_q <= StResp;
          end else begin
            div_reset <= 1'b1;
            wdog_q    <= wdog_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Scoreboard bench for div_arbiter with a behavioural divider on its far side.
module tb_div_arbiter;
  import div_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int TO = 16;

  logic          clk;
  logic          reset;
  logic [N-1:0]  req;
  logic [N*DW-1:0] a_in, b_in;
  logic [N-1:0]  ack, done;
  logic [DW-1:0] res_out;
  logic [1:0]    err_out;
  logic          div_reset, div_valid_in;
  logic [DW-1:0] div_d_in;
  logic          div_valid_out;
  logic [DW-1:0] div_d_out;
  logic          div_error_out;

  div_arbiter #(
    .N       (N),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .a_in          (a_in),
    .b_in          (b_in),
    .ack           (ack),
    .done          (done),
    .res_out       (res_out),
    .err_out       (err_out),
    .div_reset     (div_reset),
    .div_valid_in  (div_valid_in),
    .div_d_in      (div_d_in),
    .div_valid_out (div_valid_out),
    .div_d_out     (div_d_out),
    .div_error_out (div_error_out)
  );

  typedef struct {
    int            idx;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] res;
    logic [1:0]    err;
    bit            mute;
  } exp_t;

  exp_t exp_q[$];
  exp_t fly_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int vo_cyc = 0;
  int done_cnt = 0;
  int mptr;
  bit div_mute = 0;
  bit spur_en  = 0;
  logic [DW-1:0] av[N];
  logic [DW-1:0] bv[N];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  function automatic logic [DW-1:0] ref_q(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return DW'(sa / sb);
  endfunction

  // Behavioural divider: two operand strobes, answers 2..6 cycles after b.
  initial begin
    int   dv_cnt, dv_lat;
    bit   dv_busy;
    logic [DW-1:0] op_a, op_b;
    div_valid_out = 1'b0;
    div_d_out     = '0;
    div_error_out = 1'b0;
    dv_cnt  = 0;
    dv_lat  = 0;
    dv_busy = 0;
    op_a    = '0;
    op_b    = '0;
    forever begin
      @(negedge clk);
      div_valid_out = 1'b0;
      if (div_reset) begin
        dv_cnt  = 0;
        dv_busy = 0;
      end else begin
        // Stray strobe while idle; quotient left untouched
        if (spur_en && !div_mute && dv_cnt == 0 && !dv_busy && $urandom_range(0, 7) == 0)
          div_valid_out = 1'b1;
        if (div_valid_in) begin
          if (dv_cnt == 0) begin
            op_a   = div_d_in;
            dv_cnt = 1;
          end else begin
            op_b    = div_d_in;
            dv_cnt  = 0;
            dv_busy = !div_mute;
            dv_lat  = 2 + int'($urandom_range(0, 4));
          end
        end else if (dv_busy) begin
          dv_lat--;
          if (dv_lat == 0) begin
            if (op_b == '0) begin
              div_error_out = 1'b1;
              div_d_out     = '1;
            end else begin
              div_error_out = 1'b0;
              div_d_out     = ref_q(op_a, op_b);
            end
            div_valid_out = 1'b1;
            vo_cyc  = cyc;
            dv_busy = 0;
          end
        end
      end
    end
  end

  // Monitor: pops expectations on ack and done, checks strobes and timing.
  initial begin
    exp_t e;
    bit live;
    int last_ack, ack_cyc, vin_n, dr_run;
    live = 0; last_ack = -100; ack_cyc = 0; vin_n = 0; dr_run = 0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        live = 0;
        dr_run = 0;
        last_ack = -100;
      end else if (!live) begin
        live = 1;
      end else begin
        if (ack != '0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_ack", int'(ack), 0);
          end else begin
            e = exp_q.pop_front();
            chk("ack_onehot", int'(ack), 1 << e.idx);
            chk("ack_spacing_ge8", int'(cyc - last_ack >= 8), 1);
            last_ack = cyc;
            ack_cyc  = cyc;
            vin_n    = 0;
            fly_q.push_back(e);
          end
        end
        if (div_valid_in) begin
          if (fly_q.size() == 0) begin
            chk("stray_valid_in", 1, 0);
          end else begin
            vin_n++;
            if (vin_n == 1) begin
              chk("send_a_cycle", cyc - ack_cyc, 0);
              chk("send_a_data", int'(div_d_in), int'(fly_q[0].a));
            end else begin
              chk("send_b_cycle", cyc - ack_cyc, 2);
              chk("send_b_data", int'(div_d_in), int'(fly_q[0].b));
            end
          end
        end
        if (div_reset) begin
          dr_run++;
        end else if (dr_run != 0) begin
          chk("abort_reset_len", dr_run, 2);
          dr_run = 0;
        end
        if (done != '0) begin
          done_cnt++;
          if (fly_q.size() == 0) begin
            chk("unexpected_done", int'(done), 0);
          end else begin
            e = fly_q.pop_front();
            chk("done_onehot", int'(done), 1 << e.idx);
            chk("res_out", int'(res_out), int'(e.res));
            chk("err_out", int'(err_out), int'(e.err));
            chk("vin_count", vin_n, 2);
            if (e.mute) chk("timeout_latency", cyc - ack_cyc, TO + 6);
            else        chk("done_latency", cyc - vo_cyc, 2);
          end
        end
      end
    end
  end

  task automatic load_ops();
    for (int i = 0; i < N; i++) begin
      a_in[i*DW +: DW] = av[i];
      b_in[i*DW +: DW] = bv[i];
    end
  endtask

  task automatic push_exp(input int i, input bit mute);
    exp_t e;
    e.idx  = i;
    e.a    = av[i];
    e.b    = bv[i];
    e.mute = mute;
    if (mute) begin
      e.res = '0; e.err = 2'd2;
    end else if (bv[i] == '0) begin
      e.res = '0; e.err = 2'd1;
    end else begin
      e.res = ref_q(av[i], bv[i]); e.err = 2'd0;
    end
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_ack", int'(ack), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_res_out", int'(res_out), 0);
    chk("rst_err_out", int'(err_out), 0);
    chk("rst_div_valid_in", int'(div_valid_in), 0);
    chk("rst_div_d_in", int'(div_d_in), 0);
    chk("rst_div_reset", int'(div_reset), 1);
    exp_q.delete();
    fly_q.delete();
    mptr  = N - 1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_div_reset", int'(div_reset), 0);
  endtask

  // Requests in mask arrive together; expected service order is round-robin.
  task automatic run_batch(input logic [N-1:0] mask, input bit mute);
    logic [N-1:0] pend;
    int pick;
    bit ok;
    load_ops();
    div_mute = mute;
    pend = mask;
    while (pend != '0) begin
      pick = 0;
      for (int k = N; k >= 1; k--)
        if (pend[(mptr + k) % N]) pick = (mptr + k) % N;
      pend[pick] = 1'b0;
      mptr = pick;
      push_exp(pick, mute);
    end
    req = mask;
    ok  = 0;
    for (int t = 0; t < 60 * N && !ok; t++) begin
      @(posedge clk);
      #1;
      req = req & ~ack;
      if (req == '0 && exp_q.size() == 0 && fly_q.size() == 0) ok = 1;
    end
    chk("batch_finished", int'(ok), 1);
    if (!ok) do_reset();
  endtask

  initial begin
    bit ok;
    int snap;
    logic [N-1:0] mask_r;
    reset = 1'b0;
    req   = '0;
    a_in  = '0;
    b_in  = '0;
    for (int i = 0; i < N; i++) begin
      av[i] = '0;
      bv[i] = '0;
    end
    mptr = N - 1;
    do_reset();

    av[0] = DW'(6); bv[0] = DW'(3);
    run_batch(4'b0001, 1'b0);
    av[1] = DW'(5); bv[1] = DW'(0);
    run_batch(4'b0010, 1'b0);

    do_reset();
    av[0] = DW'(-7); bv[0] = DW'(-2);
    av[1] = DW'(-8); bv[1] = DW'(2);
    av[2] = DW'(2);  bv[2] = DW'(7);
    run_batch(4'b0111, 1'b0);

    av[0] = DW'(6); bv[0] = DW'(3);
    run_batch(4'b0001, 1'b1);
    run_batch(4'b0001, 1'b0);

    // Reset while the divider is being waited on: the op must vanish
    av[2] = DW'(6); bv[2] = DW'(3);
    load_ops();
    div_mute = 1;
    push_exp(2, 1'b1);
    req = 4'b0100;
    ok  = 0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(posedge clk);
      #1;
      if (ack[2]) ok = 1;
    end
    chk("wait_test_ack", int'(ok), 1);
    req = '0;
    repeat (8) @(posedge clk);
    #1;
    do_reset();
    div_mute = 0;
    snap = done_cnt;
    repeat (40) @(posedge clk);
    #1;
    chk("no_done_after_reset", done_cnt - snap, 0);
    for (int i = 0; i < N; i++) begin
      av[i] = DW'($urandom);
      bv[i] = DW'($urandom_range(1, 7));
    end
    run_batch(4'b1111, 1'b0);

    spur_en = 1;
    for (int r = 0; r < 40; r++) begin
      mask_r = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        av[i] = DW'($urandom);
        bv[i] = ($urandom_range(0, 5) == 0) ? '0 : DW'($urandom);
      end
      run_batch(mask_r, $urandom_range(0, 9) == 0);
    end
    spur_en = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Round-robin arbiter and sequencer that shares one `fsm_div` signed divider between N requesters. Each requester hands over a full operand pair (a, b) in parallel. The arbiter serialises it into the divider's two-pulse `valid_in` protocol, waits for `valid_out`, and returns the quotient and error code to the granted requester. A watchdog aborts and resets the divider if it never answers.

## Interface
- `N`, 4: number of requesters, 2..8.
- `DATA_W`, 4: operand/result width; equals the divider width.
- `TIMEOUT`, 64: maximum cycles spent in WAIT before abort; must be at least 16.

Ports:
- `clk`  in  1: single clock, all logic on rising edge.
- `reset`  in  1: synchronous, active-low.
- `req`  in  N: request per requester; held until its `ack`.
- `a_in`  in  N*DATA_W: dividend, requester i at bits [i*DATA_W +: DATA_W], two's complement.
- `b_in`  in  N*DATA_W: divisor, same packing.
- `ack`  out  N: one-cycle pulse when operands are captured.
- `done`  out  N: one-cycle pulse when a result is returned.
- `res_out`  out  DATA_W: quotient, valid in the `done` cycle, held until the next `done`.
- `err_out`  out  2: 0 none, 1 divide-by-zero, 2 timeout; same validity as `res_out`.
- `div_reset`  out  1: active-high reset to the divider.
- `div_valid_in`  out  1: operand strobe to the divider.
- `div_d_in`  out  DATA_W: operand to the divider.
- `div_valid_out`  in  1: divider result strobe.
- `div_d_out`  in  DATA_W: divider quotient.
- `div_error_out`  in  1: divider divide-by-zero flag.

## Operation
- All outputs are registered.
- Reset values: `ack`, `done`, `res_out`, `err_out`, `div_valid_in`, `div_d_in` = 0; `div_reset` = 1 while `reset` is low.
- After reset: state IDLE; round-robin pointer = N-1, so requester 0 has first priority.
- States: IDLE, SEND_A, GAP_A, SEND_B, GAP_B, WAIT, SAMPLE, RESP, ABORT.
- IDLE: if any `req` is high, choose the first set bit searching from pointer+1 upward with wrap. Capture that requester's a and b, set pointer to its index, pulse its `ack`, and go to SEND_A. `req` is sampled only in IDLE; requests arriving in other states wait.
- SEND_A: `div_valid_in`=1, `div_d_in`=a. GAP_A: `div_valid_in`=0.
- SEND_B: `div_valid_in`=1, `div_d_in`=b. GAP_B: `div_valid_in`=0.
- WAIT: clear and then increment the watchdog counter each cycle. On `div_valid_out` high, go to SAMPLE. If the counter reaches TIMEOUT-1 first, go to ABORT.
- SAMPLE: one settling cycle; at its end, capture `div_d_out` and `div_error_out`.
- RESP: pulse `done` for the granted requester. `err_out` = 1 if the captured error is set (with `res_out` = 0), else 0 with `res_out` = quotient. Then go to IDLE.
- ABORT: `div_reset` = 1 for 2 cycles, then `done` with `res_out` = 0 and `err_out` = 2, then IDLE.
- The arbiter performs no arithmetic. Quotient semantics (signed, truncation toward zero) belong to the divider; width is DATA_W throughout.
- Fairness: with all N requesting continuously, each requester is served exactly once per N operations.

## Timing
- Request seen in IDLE at cycle 0:
  - cycle 1: `ack` and SEND_A
  - cycle 2: GAP_A
  - cycle 3: SEND_B
  - cycle 4: GAP_B
  - cycle 5 onward: WAIT
- `div_valid_out` first high in WAIT cycle k: SAMPLE at k+1, `done` at k+2, IDLE at k+3.
- Minimum spacing between two `ack` pulses: 8 cycles.
- A requester must not change `a_in`/`b_in` before its `ack`; changes after `ack` are ignored.
- Multiple `req` bits high in the same cycle: exactly one `ack`, per the round-robin order.
- `div_valid_out` high outside WAIT: ignored.
- `reset` low in any state: next cycle all outputs take their reset values, the pending operation is dropped with no `done`, and the pointer returns to N-1.

## Structure
- Package `div_arb_pkg`:
  - state enum
  - error codes ERR_NONE=0, ERR_DIV0=1, ERR_TIMEOUT=2
  - DATA_W default
- Sub-module `rr_arbiter`: combinational round-robin picker. Inputs are `req[N-1:0]` and the pointer; outputs are a one-hot grant and a valid flag.
- FSM, operand registers, watchdog and output registers live in `div_arbiter`.

## Test plan
- Reset low 2 cycles, then high: all outputs 0; `div_reset` 1 during reset and 0 after; state IDLE.
- `req[0]` with a=6, b=3: `ack[0]` at cycle 1; `div_valid_in` pulses at cycles 1 and 3 carrying 6 and 3; `done[0]` with `res_out`=2, `err_out`=0.
- `req[1]` with a=5, b=0: `done[1]` with `err_out`=1, `res_out`=0.
- `req[0..2]` together (-7/-2, -8/2, 2/7): `ack` order 0, 1, 2; results 3, -4, 0, all `err_out`=0.
- Stub divider with `div_valid_out` tied low, TIMEOUT=16: `div_reset` high 2 cycles, then `done` with `err_out`=2. A following 6/3 request returns 2.
- `reset` pulled low during WAIT: no `done` is emitted; the next simultaneous `req[0..3]` is granted to 0 first.
